// File: rtl/shift_ex_stage_if.sv
// Handshake bundles for the shift execute stage: issue side and writeback side.
// Signal names keep their stage-relative direction suffixes.
interface shift_issue_if;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic        is_imm_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [4:0]  shamt_i;
    logic [4:0]  rd_i;

    modport master (output valid_i, funct3_i, funct7_i, is_imm_i, rs1_data_i,
                           rs2_data_i, shamt_i, rd_i,
                    input  ready_o);
    modport slave  (input  valid_i, funct3_i, funct7_i, is_imm_i, rs1_data_i,
                           rs2_data_i, shamt_i, rd_i,
                    output ready_o);
endinterface

interface shift_wb_if;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        wb_illegal_o;

    modport master (output wb_valid_o, wb_rd_o, wb_data_o, wb_illegal_o,
                    input  wb_ready_i);
    modport slave  (input  wb_valid_o, wb_rd_o, wb_data_o, wb_illegal_o,
                    output wb_ready_i);
endinterface

// File: rtl/shift_ex_stage.sv
// Two-entry RV32I shift execute stage: S1 drives the external shifter,
// S2 registers the result toward writeback.
module shift_ex_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    shift_issue_if.slave     iss,
    output logic [31:0]      sh_operand_a_o,
    output logic [4:0]       sh_amount_o,
    output logic             sh_left_o,
    output logic             sh_arith_o,
    input  logic [31:0]      sh_result_i,
    shift_wb_if.master       wb,
    output logic [CNT_W-1:0] shift_count_o
);
    logic             r_s1_valid;
    logic [31:0]      r_s1_a;
    logic [4:0]       r_s1_amt;
    logic             r_s1_left;
    logic             r_s1_arith;
    logic [4:0]       r_s1_rd;
    logic             r_s1_ill;

    logic             r_s2_valid;
    logic [31:0]      r_s2_data;
    logic [4:0]       r_s2_rd;
    logic             r_s2_ill;

    logic [CNT_W-1:0] r_count;

    logic             w_s2_free;
    logic             w_s1_adv;
    logic             w_accept;
    logic             w_wb_hs;
    logic             w_left;
    logic             w_arith;
    logic             w_ill;
    logic [4:0]       w_amt;

    assign w_s2_free  = !r_s2_valid || wb.wb_ready_i;
    assign w_s1_adv   = r_s1_valid && w_s2_free;
    assign iss.ready_o = !rst_i && (!r_s1_valid || w_s2_free);
    assign w_accept   = iss.valid_i && iss.ready_o;
    assign w_wb_hs    = r_s2_valid && wb.wb_ready_i;

    always_comb begin
        w_left  = 1'b0;
        w_arith = 1'b0;
        w_ill   = 1'b1;
        w_amt   = iss.is_imm_i ? iss.shamt_i : iss.rs2_data_i[4:0];
        if (iss.funct3_i == 3'b001 && iss.funct7_i == 7'b0000000) begin
            w_left = 1'b1;
            w_ill  = 1'b0;
        end else if (iss.funct3_i == 3'b101 && iss.funct7_i == 7'b0000000) begin
            w_ill  = 1'b0;
        end else if (iss.funct3_i == 3'b101 && iss.funct7_i == 7'b0100000) begin
            w_arith = 1'b1;
            w_ill   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_amt   <= '0;
            r_s1_left  <= 1'b0;
            r_s1_arith <= 1'b0;
            r_s1_rd    <= '0;
            r_s1_ill   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_rd    <= '0;
            r_s2_ill   <= 1'b0;
            r_count    <= '0;
        end else begin
            // A writeback handshake in the flush cycle has already happened, so it counts.
            if (w_wb_hs) r_count <= r_count + 1'b1;
            if (flush_i) begin
                r_s1_valid <= 1'b0;
                r_s2_valid <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_s1_valid <= 1'b1;
                    r_s1_a     <= iss.rs1_data_i;
                    r_s1_amt   <= w_amt;
                    r_s1_left  <= w_left;
                    r_s1_arith <= w_arith;
                    r_s1_rd    <= iss.rd_i;
                    r_s1_ill   <= w_ill;
                end else if (w_s1_adv) begin
                    r_s1_valid <= 1'b0;
                end

                if (w_s1_adv) begin
                    r_s2_valid <= 1'b1;
                    r_s2_data  <= (r_s1_ill || r_s1_rd == 5'd0) ? 32'd0 : sh_result_i;
                    r_s2_rd    <= r_s1_rd;
                    r_s2_ill   <= r_s1_ill;
                end else if (w_wb_hs) begin
                    r_s2_valid <= 1'b0;
                end
            end
        end
    end

    assign sh_operand_a_o  = r_s1_a;
    assign sh_amount_o     = r_s1_amt;
    assign sh_left_o       = r_s1_left;
    assign sh_arith_o      = r_s1_arith;

    assign wb.wb_valid_o   = r_s2_valid;
    assign wb.wb_data_o    = r_s2_data;
    assign wb.wb_rd_o      = r_s2_rd;
    assign wb.wb_illegal_o = r_s2_ill;

    assign shift_count_o   = r_count;
endmodule

// File: tb/tb_shift_ex_stage.sv
// Bench for shift_ex_stage: in-order result queue model checked every cycle,
// plus directed vectors with literal expectations.
module tb_shift_ex_stage;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst, flush;
    logic [31:0] sh_a, sh_res;
    logic [4:0]  sh_amt;
    logic        sh_left, sh_arith;
    logic [CNT_W-1:0] cnt;

    shift_issue_if iss ();
    shift_wb_if    wb ();

    shift_ex_stage #(.CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .iss(iss),
        .sh_operand_a_o(sh_a), .sh_amount_o(sh_amt), .sh_left_o(sh_left),
        .sh_arith_o(sh_arith), .sh_result_i(sh_res), .wb(wb), .shift_count_o(cnt)
    );

    always #5 clk = ~clk;

    // external combinational shifter
    assign sh_res = sh_left ? (sh_a << sh_amt)
                  : (sh_arith ? $unsigned($signed(sh_a) >>> sh_amt) : (sh_a >> sh_amt));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ill;
        int          cyc;
    } ent_t;

    ent_t q[$];
    int   edge_n = 0;
    int   m_cnt  = 0;
    logic m_acc  = 1'b0;

    function automatic ent_t predict(input logic [2:0] f3, input logic [6:0] f7,
                                     input logic imm, input logic [31:0] a,
                                     input logic [31:0] b, input logic [4:0] sa,
                                     input logic [4:0] rd);
        ent_t e;
        int   amt;
        logic [31:0] res;
        amt = imm ? int'(sa) : int'(b[4:0]);
        e.ill = !((f3 == 3'd1 && f7 == 7'd0) ||
                  (f3 == 3'd5 && (f7 == 7'd0 || f7 == 7'h20)));
        if (f3 == 3'd1)     res = a << amt;
        else if (f7 == 7'd0) res = a >> amt;
        else                res = $unsigned($signed(a) >>> amt);
        e.rd   = rd;
        e.data = (e.ill || rd == 5'd0) ? 32'd0 : res;
        e.cyc  = edge_n;
        return e;
    endfunction

    function automatic logic m_ready();
        return !rst && (q.size() < 2 || wb.wb_ready_i);
    endfunction

    function automatic logic m_wbv();
        return q.size() > 0 && (q[0].cyc + 1 < edge_n);
    endfunction

    // model update at each active edge, from inputs driven before it
    always @(posedge clk) begin
        logic acc, hs;
        m_acc = 1'b0;
        if (rst) begin
            q.delete();
            m_cnt = 0;
        end else begin
            acc = iss.valid_i && m_ready();
            hs  = m_wbv() && wb.wb_ready_i;
            if (hs) begin
                void'(q.pop_front());
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end
            if (flush) q.delete();
            else if (acc) begin
                q.push_back(predict(iss.funct3_i, iss.funct7_i, iss.is_imm_i,
                                    iss.rs1_data_i, iss.rs2_data_i, iss.shamt_i, iss.rd_i));
                m_acc = 1'b1;
            end
        end
        edge_n++;
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (edge_n > 0) begin
            chk("ready", {31'd0, iss.ready_o}, {31'd0, m_ready()});
            chk("wb_valid", {31'd0, wb.wb_valid_o}, {31'd0, m_wbv()});
            if (m_wbv()) begin
                chk("wb_rd", {27'd0, wb.wb_rd_o}, {27'd0, q[0].rd});
                chk("wb_data", wb.wb_data_o, q[0].data);
                chk("wb_illegal", {31'd0, wb.wb_illegal_o}, {31'd0, q[0].ill});
            end
            chk("count", {28'd0, cnt}, m_cnt[31:0]);
        end
    end

    task automatic set_in(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sa, input logic [4:0] rd);
        iss.valid_i = 1'b1; iss.funct3_i = f3; iss.funct7_i = f7; iss.is_imm_i = imm;
        iss.rs1_data_i = a; iss.rs2_data_i = b; iss.shamt_i = sa; iss.rd_i = rd;
    endtask

    task automatic wait_acc();
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (m_acc) break;
        end
        if (!m_acc) chk("accept_timeout", 32'd0, 32'd1);
        iss.valid_i = 1'b0;
    endtask

    task automatic push(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sa, input logic [4:0] rd);
        set_in(f3, f7, imm, a, b, sa, rd);
        wait_acc();
    endtask

    // single instruction with wb_ready=1, literal checks on the result
    task automatic one_shot(input string nm, input logic [2:0] f3, input logic [6:0] f7,
                            input logic imm, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] sa, input logic [4:0] rd,
                            input logic exp_left, input logic [31:0] exp_data,
                            input logic exp_ill);
        push(f3, f7, imm, a, b, sa, rd);
        chk({nm, "_sh_left"}, {31'd0, sh_left}, {31'd0, exp_left});
        @(posedge clk); @(negedge clk);
        chk({nm, "_valid"}, {31'd0, wb.wb_valid_o}, 32'd1);
        chk({nm, "_rd"}, {27'd0, wb.wb_rd_o}, {27'd0, rd});
        chk({nm, "_data"}, wb.wb_data_o, exp_data);
        chk({nm, "_ill"}, {31'd0, wb.wb_illegal_o}, {31'd0, exp_ill});
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_sh_a"}, sh_a, 32'd0);
        chk({nm, "_sh_amt"}, {27'd0, sh_amt}, 32'd0);
        chk({nm, "_sh_lr"}, {30'd0, sh_left, sh_arith}, 32'd0);
        chk({nm, "_wbv"}, {31'd0, wb.wb_valid_o}, 32'd0);
        chk({nm, "_wbd"}, wb.wb_data_o, 32'd0);
        chk({nm, "_wbrd"}, {27'd0, wb.wb_rd_o}, 32'd0);
        chk({nm, "_wbill"}, {31'd0, wb.wb_illegal_o}, 32'd0);
        chk({nm, "_cnt"}, {28'd0, cnt}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wb.wb_ready_i = 1'b0;
        set_in(3'd0, 7'd0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0);
        iss.valid_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, iss.ready_o}, 32'd0);
        chk_all_zero("rst");
        rst = 1'b0; wb.wb_ready_i = 1'b1;
        @(posedge clk); #1;

        one_shot("slli", 3'b001, 7'd0, 1'b1, 32'h0000_0001, 32'd0, 5'd31, 5'd5,
                 1'b1, 32'h8000_0000, 1'b0);
        one_shot("sra", 3'b101, 7'h20, 1'b0, 32'h8000_00F0, 32'hFFFF_FFE4, 5'd0, 5'd3,
                 1'b0, 32'hF800_000F, 1'b0);
        one_shot("srl", 3'b101, 7'h00, 1'b0, 32'h8000_00F0, 32'hFFFF_FFE4, 5'd0, 5'd3,
                 1'b0, 32'h0800_000F, 1'b0);

        // back-to-back stream of 8
        for (int i = 0; i < 8; i++) begin
            push((i % 2) ? 3'b101 : 3'b001, (i % 3 == 2) ? 7'h20 : 7'h00, i[0],
                 32'hA5C3_0F01 + i * 32'h1111_1111, 32'd0 + i, 5'(3 * i), 5'(i + 1));
            chk("stream_ready", {31'd0, iss.ready_o}, 32'd1);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stream_cnt", {28'd0, cnt}, 32'd11);

        // stall: two accepted, third blocked while writeback is stalled
        @(posedge clk); #1;
        wb.wb_ready_i = 1'b0;
        push(3'b001, 7'd0, 1'b1, 32'h0000_0003, 32'd0, 5'd4, 5'd7);
        push(3'b101, 7'd0, 1'b1, 32'hF000_0000, 32'd0, 5'd8, 5'd8);
        set_in(3'b101, 7'h20, 1'b1, 32'hF000_0000, 32'd0, 5'd8, 5'd9);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_ready", {31'd0, iss.ready_o}, 32'd0);
            chk("stall_data", wb.wb_data_o, 32'h0000_0030);
        end
        wb.wb_ready_i = 1'b1;
        wait_acc();
        repeat (3) @(posedge clk); #1;

        one_shot("illegal", 3'b001, 7'h20, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd4,
                 1'b0, 32'd0, 1'b1);
        one_shot("rd0", 3'b001, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd0,
                 1'b1, 32'd0, 1'b0);
        @(negedge clk);
        chk("wrap_cnt", {28'd0, cnt}, 32'd0);

        // flush with pipeline full and an input presented
        @(posedge clk); #1;
        wb.wb_ready_i = 1'b0;
        push(3'b001, 7'd0, 1'b1, 32'h0000_0011, 32'd0, 5'd1, 5'd10);
        push(3'b001, 7'd0, 1'b1, 32'h0000_0022, 32'd0, 5'd2, 5'd11);
        set_in(3'b001, 7'd0, 1'b1, 32'h0000_0033, 32'd0, 5'd3, 5'd12);
        flush = 1'b1; wb.wb_ready_i = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; iss.valid_i = 1'b0;
        @(negedge clk);
        chk("flush_wbv", {31'd0, wb.wb_valid_o}, 32'd0);
        chk("flush_ready", {31'd0, iss.ready_o}, 32'd1);
        chk("flush_cnt", {28'd0, cnt}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("flush_empty", {31'd0, wb.wb_valid_o}, 32'd0);

        // reset mid-stream
        @(posedge clk); #1;
        push(3'b101, 7'h20, 1'b1, 32'h8765_4321, 32'd0, 5'd5, 5'd13);
        push(3'b001, 7'h00, 1'b1, 32'h1234_5678, 32'd0, 5'd6, 5'd14);
        set_in(3'b101, 7'h00, 1'b1, 32'hFFFF_0000, 32'd0, 5'd7, 5'd15);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {31'd0, iss.ready_o}, 32'd0);
        @(posedge clk); #1;
        chk_all_zero("midrst");
        rst = 1'b0; iss.valid_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("post_rst_wbv", {31'd0, wb.wb_valid_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
